multi_time_base: RTL and testbench
==================================

Name: multi_time_base

Overview:
- Parametrised successor of the single-rate tick generator.
- A shared prescaler derives a base tick at FREQ_BASE from clk.
- NB_CHAN independent channels divide that base tick by a runtime-programmable divisor. Each channel runs in periodic or one-shot mode.
- Feeds game timing: alien step rate, missile speed, blink and timeout events, all from one block.

Parameters:
- FREQ_CLK, 50000000, input clock frequency in Hz.
- FREQ_BASE, 20000, base tick frequency in Hz; must satisfy 1 <= FREQ_BASE <= FREQ_CLK.
- NB_CHAN, 4, number of channels, >= 1.
- DIV_WIDTH, 16, width of per-channel divisor and counter.
- DIV_DEFAULT, 1000, divisor loaded into every channel at reset; must be < 2^DIV_WIDTH.
- Derived: NB_TIC = FREQ_CLK/FREQ_BASE (integer division). PRE_W = bit size of NB_TIC. CHAN_W = max(1, ceil(log2(NB_CHAN))).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  NB_CHAN  per-channel enable.
- start  in  NB_CHAN  per-channel one-shot trigger, 1-cycle pulse.
- cfg_we  in  1  configuration write strobe.
- cfg_chan  in  CHAN_W  target channel of the write.
- cfg_div  in  DIV_WIDTH  divisor to load.
- cfg_oneshot  in  1  mode to load: 1 = one-shot, 0 = periodic.
- base_tick  out  1  prescaler tick.
- pulse  out  NB_CHAN  channel expiry pulses.
- busy  out  NB_CHAN  channel is counting.

Behaviour:
- Reset (reset_n low, asynchronous):
  - prescaler := 0; every channel counter := 0.
  - div := DIV_DEFAULT; mode := periodic; run := 0.
  - base_tick, pulse and busy are forced to 0 while reset_n is low.
  - Release is synchronous to clk; first count on the first rising edge after release.
- Prescaler:
  - Counts 0..NB_TIC-1, then wraps to 0.
  - base_tick = (prescaler == NB_TIC-1); combinational, high for 1 cycle every NB_TIC cycles.
  - NB_TIC = 1: base_tick is high every cycle out of reset.
- Channel state, per channel i: cnt[DIV_WIDTH], div, mode, run.
- Periodic mode:
  - run follows enable[i], registered.
  - enable[i] = 0 clears run and cnt.
- One-shot mode:
  - start[i] & enable[i] sets run := 1, cnt := 0.
  - Expiry clears run.
  - enable[i] = 0 aborts: run := 0, cnt := 0.
  - start[i] with enable[i] = 0 is ignored.
  - start[i] in periodic mode is ignored.
- Counting: on a cycle with run & base_tick:
  - if cnt == div-1: cnt := 0 and the channel expires.
  - else cnt := cnt + 1.
- Expiry output:
  - pulse[i] = run & base_tick & (cnt == div-1) & (div != 0); combinational, same cycle as the expiring base_tick.
  - First pulse comes on the div-th base_tick after run is set.
- div == 0 means the channel is stalled: cnt is held, no pulse ever, busy still reflects run.
- div == 1 means a pulse on every base_tick while running.
- busy[i] = run.
- Config write (cfg_we = 1, cfg_chan < NB_CHAN):
  - Loads div and mode on the next edge and clears cnt.
  - run is kept in periodic mode.
  - run is cleared on a switch into one-shot.
  - cfg_chan >= NB_CHAN: write ignored.
- Simultaneous events:
  - cfg_we and expiry on the same channel: pulse is still emitted this cycle; the write wins for the next state.
  - start and expiry in one-shot: pulse is emitted; run stays 1 and cnt := 0 (restart wins).
  - Enable drop and expiry: pulse is emitted, then the channel stops.
- No width wrap issues: cnt never exceeds div-1 <= 2^DIV_WIDTH-2.

Test Plan (bench params FREQ_CLK=100, FREQ_BASE=10, so NB_TIC=10; NB_CHAN=4, DIV_WIDTH=8, DIV_DEFAULT=3):
- Reset release, all enables 0:
  - base_tick high on cycles 10, 20, 30...
  - pulse and busy stay 0.
  - Assert reset_n low mid-count: outputs go to 0 immediately, without a clock edge.
- Periodic, channel 0: enable[0]=1, default div 3:
  - pulse[0] coincides with every 3rd base_tick, i.e. a 30-cycle period, exactly 1 cycle wide.
  - Drop enable: no further pulses, cnt returns to 0.
- Runtime reprogramming:
  - cfg_we, chan 1, div 5, periodic, enable[1]=1: period is 50 cycles.
  - Write div 1: pulse[1] equals base_tick.
  - Write div 0: pulse[1] stays 0 while busy[1] stays 1.
  - cfg_chan=7: no channel changes.
- One-shot, channel 2: write div 4, oneshot=1; enable[2]=1; pulse start[2]:
  - busy[2] rises next cycle.
  - Exactly one pulse[2], on the 4th base_tick; busy[2] falls after it.
  - start without enable: no effect.
- Collisions:
  - start[2] on the expiry cycle: pulse emitted and a new 4-tick run begins.
  - cfg_we on the expiry cycle of channel 0: pulse emitted, cnt=0, new div used thereafter.
- NB_TIC=1 build (FREQ_BASE=FREQ_CLK): base_tick constantly 1; channel with div 2 pulses every 2nd cycle.

Source files
------------

// File: rtl/multi_time_base.sv
// Shared prescaler producing a base tick, plus NB_CHAN runtime-programmable
// dividers on that tick, each running periodic or one-shot.
module multi_time_base #(
  parameter int FREQ_CLK    = 50000000,
  parameter int FREQ_BASE   = 20000,
  parameter int NB_CHAN     = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int DIV_DEFAULT = 1000,
  localparam int NB_TIC = FREQ_CLK / FREQ_BASE,
  localparam int PRE_W  = $clog2(NB_TIC + 1),
  localparam int CHAN_W = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NB_CHAN-1:0]   enable,
  input  logic [NB_CHAN-1:0]   start,
  input  logic                 cfg_we,
  input  logic [CHAN_W-1:0]    cfg_chan,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 cfg_oneshot,
  output logic                 base_tick,
  output logic [NB_CHAN-1:0]   pulse,
  output logic [NB_CHAN-1:0]   busy
);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_raw;

  logic [DIV_WIDTH-1:0] cnt_q [NB_CHAN];
  logic [DIV_WIDTH-1:0] cnt_d [NB_CHAN];
  logic [DIV_WIDTH-1:0] div_q [NB_CHAN];
  logic [DIV_WIDTH-1:0] div_d [NB_CHAN];
  logic [NB_CHAN-1:0]   mode_q, mode_d;
  logic [NB_CHAN-1:0]   run_q, run_d;
  logic [NB_CHAN-1:0]   hit, adv;

  assign tick_raw = (pre_q == PRE_W'(NB_TIC - 1));
  assign pre_d    = tick_raw ? '0 : pre_q + 1'b1;

  // Gated so a constant tick (NB_TIC == 1) still reads 0 during reset.
  assign base_tick = tick_raw & reset_n;
  assign pulse     = hit & {NB_CHAN{reset_n}};
  assign busy      = run_q;

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    mode_d = mode_q;
    run_d  = run_q;
    hit    = '0;
    adv    = '0;
    for (int i = 0; i < NB_CHAN; i++) begin
      adv[i] = run_q[i] & tick_raw & (div_q[i] != '0);
      hit[i] = adv[i] & (cnt_q[i] == div_q[i] - DIV_WIDTH'(1));
      if (!enable[i]) begin
        run_d[i] = 1'b0;
        cnt_d[i] = '0;
      end else if (!mode_q[i]) begin
        run_d[i] = 1'b1;
        if (hit[i])      cnt_d[i] = '0;
        else if (adv[i]) cnt_d[i] = cnt_q[i] + DIV_WIDTH'(1);
      end else if (start[i]) begin
        run_d[i] = 1'b1;
        cnt_d[i] = '0;
      end else if (hit[i]) begin
        run_d[i] = 1'b0;
        cnt_d[i] = '0;
      end else if (adv[i]) begin
        cnt_d[i] = cnt_q[i] + DIV_WIDTH'(1);
      end
      // Out-of-range cfg_chan values match no channel and are dropped.
      if (cfg_we && (cfg_chan == CHAN_W'(i))) begin
        div_d[i]  = cfg_div;
        mode_d[i] = cfg_oneshot;
        cnt_d[i]  = '0;
        if (cfg_oneshot && !mode_q[i]) run_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q  <= '0;
      mode_q <= '0;
      run_q  <= '0;
      for (int i = 0; i < NB_CHAN; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DIV_WIDTH'(DIV_DEFAULT);
      end
    end else begin
      pre_q  <= pre_d;
      mode_q <= mode_d;
      run_q  <= run_d;
      for (int i = 0; i < NB_CHAN; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_time_base.sv
// Self-checking bench for multi_time_base: a tick-counting reference model on
// the 10-cycle prescaler build, plus a single-cycle-prescaler build.
module tb_multi_time_base;
  localparam int NB_TIC = 10;

  logic       clk, reset_n;
  logic [3:0] en, st;
  logic       we;
  logic [1:0] ch;
  logic [7:0] dv;
  logic       os;
  logic       base_tick;
  logic [3:0] pulse, busy;

  logic [2:0] en1, st1;
  logic       we1;
  logic [1:0] ch1;
  logic [7:0] dv1;
  logic       os1;
  logic       bt1;
  logic [2:0] pulse1, busy1;

  int checks = 0;
  int errors = 0;

  // Reference model: base ticks counted since the current run began.
  int m_k;
  int m_div [4];
  bit m_os  [4];
  bit m_run [4];
  int m_t   [4];

  multi_time_base #(.FREQ_CLK(100), .FREQ_BASE(10), .NB_CHAN(4), .DIV_WIDTH(8), .DIV_DEFAULT(3)) dut (
    .clk(clk), .reset_n(reset_n), .enable(en), .start(st), .cfg_we(we), .cfg_chan(ch),
    .cfg_div(dv), .cfg_oneshot(os), .base_tick(base_tick), .pulse(pulse), .busy(busy));

  multi_time_base #(.FREQ_CLK(100), .FREQ_BASE(100), .NB_CHAN(3), .DIV_WIDTH(8), .DIV_DEFAULT(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(en1), .start(st1), .cfg_we(we1), .cfg_chan(ch1),
    .cfg_div(dv1), .cfg_oneshot(os1), .base_tick(bt1), .pulse(pulse1), .busy(busy1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic m_bt();
    return (m_k == NB_TIC - 1);
  endfunction

  function automatic logic [3:0] m_pulse();
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (m_div[i] != 0)
        r[i] = m_run[i] && m_bt() && ((m_t[i] + 1) % m_div[i] == 0);
    return r;
  endfunction

  function automatic logic [3:0] m_busy();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_run[i];
    return r;
  endfunction

  task automatic model_reset();
    m_k = 0;
    for (int i = 0; i < 4; i++) begin
      m_div[i] = 3; m_os[i] = 0; m_run[i] = 0; m_t[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [3:0] p;
    logic       bt;
    p  = m_pulse();
    bt = m_bt();
    for (int i = 0; i < 4; i++) begin
      if (!en[i]) begin
        m_run[i] = 0; m_t[i] = 0;
      end else if (!m_os[i]) begin
        if (m_run[i] && bt && m_div[i] != 0) m_t[i]++;
        m_run[i] = 1;
      end else if (st[i]) begin
        m_run[i] = 1; m_t[i] = 0;
      end else if (p[i]) begin
        m_run[i] = 0; m_t[i] = 0;
      end else if (m_run[i] && bt && m_div[i] != 0) begin
        m_t[i]++;
      end
      if (we && ch == 2'(i)) begin
        m_div[i] = dv;
        m_t[i]   = 0;
        if (os && !m_os[i]) m_run[i] = 0;
        m_os[i] = os;
      end
    end
    m_k = (m_k + 1) % NB_TIC;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    st = '0; we = 1'b0; st1 = '0; we1 = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_b;
    bit   found;
    reset_n = 1'b0;
    en = '0; st = '0; we = 0; ch = '0; dv = '0; os = 0;
    en1 = '0; st1 = '0; we1 = 0; ch1 = '0; dv1 = '0; os1 = 0;
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if ({base_tick, pulse, busy, bt1, pulse1, busy1} !== '0) begin
      errors++;
      $display("FAIL reset_hold got bt=%b pulse=%b busy=%b bt1=%b pulse1=%b busy1=%b want all 0",
               base_tick, pulse, busy, bt1, pulse1, busy1);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 35; c++) begin
      #3;
      exp_b = ((c + 1) % 10 == 0);
      checks++;
      if (base_tick !== exp_b || pulse !== 4'b0 || busy !== 4'b0) begin
        errors++;
        $display("FAIL reset_release c=%0d got bt=%b pulse=%b busy=%b want bt=%b pulse=0 busy=0",
                 c, base_tick, pulse, busy, exp_b);
      end
      tick();
    end
    en = 4'b0001;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (m_bt() && m_run[0]) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL async_reset_setup got no busy base tick want one within 40 cycles");
    end else begin
      #1;
      checks++;
      if (base_tick !== 1'b1 || busy[0] !== 1'b1) begin
        errors++;
        $display("FAIL async_reset_pre got bt=%b busy0=%b want 1/1", base_tick, busy[0]);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({base_tick, pulse, busy, bt1, pulse1, busy1} !== '0) begin
        errors++;
        $display("FAIL async_reset got bt=%b pulse=%b busy=%b bt1=%b want all 0 without an edge",
                 base_tick, pulse, busy, bt1);
      end
    end
    en = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_periodic();
    int last;
    last = -1;
    en = 4'b0001;
    for (int c = 0; c < 120; c++) begin
      #3;
      checks++;
      if (base_tick !== m_bt() || pulse !== m_pulse() || busy !== m_busy()) begin
        errors++;
        $display("FAIL periodic c=%0d got bt/pulse/busy %b/%b/%b want %b/%b/%b",
                 c, base_tick, pulse, busy, m_bt(), m_pulse(), m_busy());
      end
      if (pulse[0] === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (c - last != 30) begin
            errors++;
            $display("FAIL periodic_period got %0d want 30", c - last);
          end
        end
        last = c;
      end
      tick();
    end
    checks++;
    if (last < 0) begin
      errors++;
      $display("FAIL periodic_seen got no pulse[0] want pulses");
    end
    for (int ph = 0; ph < 2; ph++) begin
      en = (ph == 0) ? 4'b0000 : 4'b0001;
      for (int c = 0; c < 40; c++) begin
        #3;
        checks++;
        if (base_tick !== m_bt() || pulse !== m_pulse() || busy !== m_busy()) begin
          errors++;
          $display("FAIL periodic_toggle ph=%0d c=%0d got bt/pulse/busy %b/%b/%b want %b/%b/%b",
                   ph, c, base_tick, pulse, busy, m_bt(), m_pulse(), m_busy());
        end
        tick();
      end
    end
    en = '0;
  endtask

  task automatic test_reprogram();
    int last;
    last = -1;
    we = 1; ch = 2'd1; dv = 8'd5; os = 0; en = 4'b0010;
    for (int c = 0; c < 140; c++) begin
      #3;
      checks++;
      if (base_tick !== m_bt() || pulse !== m_pulse() || busy !== m_busy()) begin
        errors++;
        $display("FAIL reprog_div5 c=%0d got bt/pulse/busy %b/%b/%b want %b/%b/%b",
                 c, base_tick, pulse, busy, m_bt(), m_pulse(), m_busy());
      end
      if (pulse[1] === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (c - last != 50) begin
            errors++;
            $display("FAIL reprog_period got %0d want 50", c - last);
          end
        end
        last = c;
      end
      tick();
    end
    we = 1; ch = 2'd1; dv = 8'd1; os = 0;
    for (int c = 0; c < 40; c++) begin
      #3;
      checks++;
      if (pulse !== m_pulse() || busy !== m_busy() || (c >= 1 && pulse[1] !== base_tick)) begin
        errors++;
        $display("FAIL reprog_div1 c=%0d got pulse=%b bt=%b want pulse=%b and pulse1==bt",
                 c, pulse, base_tick, m_pulse());
      end
      tick();
    end
    we = 1; ch = 2'd1; dv = 8'd0; os = 0;
    for (int c = 0; c < 40; c++) begin
      #3;
      checks++;
      if (pulse !== m_pulse() || busy !== m_busy() || (c >= 1 && (pulse[1] !== 1'b0 || busy[1] !== 1'b1))) begin
        errors++;
        $display("FAIL reprog_div0 c=%0d got pulse=%b busy=%b want pulse=%b busy=%b",
                 c, pulse, busy, m_pulse(), m_busy());
      end
      tick();
    end
    en = '0;
  endtask

  task automatic test_oneshot();
    int nb, np;
    we = 1; ch = 2'd2; dv = 8'd4; os = 1; en = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #3;
      checks++;
      if (busy !== m_busy() || pulse !== m_pulse()) begin
        errors++;
        $display("FAIL oneshot_cfg c=%0d got pulse/busy %b/%b want %b/%b", c, pulse, busy, m_pulse(), m_busy());
      end
      tick();
    end
    st[2] = 1'b1;
    nb = 0; np = 0;
    for (int c = 0; c < 60; c++) begin
      #3;
      checks++;
      if (base_tick !== m_bt() || pulse !== m_pulse() || busy !== m_busy() || (c == 1 && busy[2] !== 1'b1)) begin
        errors++;
        $display("FAIL oneshot c=%0d got bt/pulse/busy %b/%b/%b want %b/%b/%b",
                 c, base_tick, pulse, busy, m_bt(), m_pulse(), m_busy());
      end
      if (c >= 1 && base_tick === 1'b1) nb++;
      if (pulse[2] === 1'b1) begin
        np++;
        checks++;
        if (nb != 4) begin
          errors++;
          $display("FAIL oneshot_when got pulse on base tick %0d want 4", nb);
        end
      end
      tick();
    end
    checks++;
    if (np != 1 || busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_count got pulses=%0d busy2=%b want 1/0", np, busy[2]);
    end
    en = '0; st[2] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #3;
      checks++;
      if (busy !== m_busy() || busy[2] !== 1'b0 || pulse[2] !== 1'b0) begin
        errors++;
        $display("FAIL oneshot_noen c=%0d got busy=%b pulse=%b want busy2=0 pulse2=0", c, busy, pulse);
      end
      tick();
    end
  endtask

  task automatic test_collision();
    bit         found;
    int         nb, np, first;
    logic [3:0] mp;
    en = 4'b0100; st[2] = 1'b1;
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      #3;
      checks++;
      if (pulse !== m_pulse() || busy !== m_busy()) begin
        errors++;
        $display("FAIL coll_start_run c=%0d got pulse/busy %b/%b want %b/%b", c, pulse, busy, m_pulse(), m_busy());
      end
      tick();
      mp = m_pulse();
      if (mp[2]) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL coll_start got no expiry want one within 60 cycles");
    end else begin
      st[2] = 1'b1;
      #3;
      checks++;
      if (pulse[2] !== 1'b1) begin
        errors++;
        $display("FAIL coll_start_pulse got %b want 1", pulse[2]);
      end
      tick();
      nb = 0; np = 0;
      for (int c = 0; c < 45; c++) begin
        #3;
        checks++;
        if (pulse !== m_pulse() || busy !== m_busy() || (np == 0 && busy[2] !== 1'b1)) begin
          errors++;
          $display("FAIL coll_restart c=%0d got pulse/busy %b/%b want %b/%b", c, pulse, busy, m_pulse(), m_busy());
        end
        if (base_tick === 1'b1) nb++;
        if (pulse[2] === 1'b1) begin
          np++;
          checks++;
          if (nb != 4) begin
            errors++;
            $display("FAIL coll_restart_when got base tick %0d want 4", nb);
          end
        end
        tick();
      end
      checks++;
      if (np != 1) begin
        errors++;
        $display("FAIL coll_restart_count got %0d want 1", np);
      end
    end
    en = 4'b0001;
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      tick();
      mp = m_pulse();
      if (mp[0]) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL coll_cfg got no expiry want one within 60 cycles");
    end else begin
      we = 1; ch = 2'd0; dv = 8'd2; os = 0;
      #3;
      checks++;
      if (pulse[0] !== 1'b1) begin
        errors++;
        $display("FAIL coll_cfg_pulse got %b want 1", pulse[0]);
      end
      tick();
      first = -1;
      for (int c = 0; c < 50; c++) begin
        #3;
        checks++;
        if (pulse !== m_pulse() || busy !== m_busy()) begin
          errors++;
          $display("FAIL coll_cfg_run c=%0d got pulse/busy %b/%b want %b/%b", c, pulse, busy, m_pulse(), m_busy());
        end
        if (pulse[0] === 1'b1 && first < 0) first = c;
        tick();
      end
      checks++;
      if (first != 19) begin
        errors++;
        $display("FAIL coll_cfg_next got first pulse at %0d want 19", first);
      end
    end
    en = '0;
  endtask

  task automatic test_random();
    int idx;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(15) == 0) begin
        idx = $urandom_range(3);
        en[idx] = ~en[idx];
      end
      st = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0;
      if ($urandom_range(19) == 0) begin
        we = 1; ch = 2'($urandom); dv = 8'($urandom_range(6)); os = 1'($urandom);
      end
      #3;
      checks++;
      if (base_tick !== m_bt() || pulse !== m_pulse() || busy !== m_busy()) begin
        errors++;
        $display("FAIL random c=%0d got bt/pulse/busy %b/%b/%b want %b/%b/%b",
                 c, base_tick, pulse, busy, m_bt(), m_pulse(), m_busy());
      end
      tick();
    end
    en = '0;
  endtask

  task automatic test_nbtic1();
    logic [2:0] exp_p, exp_b;
    en1 = 3'b111;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        we1 = 1; ch1 = 2'd3; dv1 = 8'd7; os1 = 1;
      end
      #3;
      exp_b = (c >= 1) ? 3'b111 : 3'b000;
      exp_p = (c >= 2 && c % 2 == 0) ? 3'b111 : 3'b000;
      checks++;
      if (bt1 !== 1'b1 || pulse1 !== exp_p || busy1 !== exp_b) begin
        errors++;
        $display("FAIL nbtic1 c=%0d got bt=%b pulse=%b busy=%b want 1/%b/%b", c, bt1, pulse1, busy1, exp_p, exp_b);
      end
      tick();
    end
    en1 = '0;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_reprogram();
    test_oneshot();
    test_collision();
    test_random();
    test_nbtic1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
